// File: rtl/ring_pkg.sv
// ============================================================================
// Module  : ring_pkg
// Brief   : Shared flit control codes, FIFO selectors and injector FSM states.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ring_pkg;

    localparam int FLIT_W = 16;

    localparam logic [1:0] CTRL_NONE = 2'b00;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

    localparam logic [1:0] DF_NONE = 2'b00;
    localparam logic [1:0] DF_REQ  = 2'b01;
    localparam logic [1:0] DF_REP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2,
        ST_TAIL = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/ring_ni_tx.sv
// ============================================================================
// Module  : ring_ni_tx
// Brief   : Ring node local injector; serializes one core message into flits.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ring_ni_tx
    import ring_pkg::*;
#(
    parameter int          FLIT_W       = ring_pkg::FLIT_W,
    parameter logic [15:0] MSG_CNT_INIT = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                msg_valid,
    output logic                msg_ready,
    input  logic [4*FLIT_W-1:0] msg_data,
    input  logic [1:0]          msg_len,
    input  logic                msg_type,
    input  logic                en_local_req_in,
    input  logic                en_local_rep_in,
    output logic [FLIT_W-1:0]   flit_out,
    output logic [1:0]          ctrl_out,
    output logic [1:0]          dest_fifo_out,
    output logic                busy,
    output logic [15:0]         msg_cnt
);

    localparam int BUF_W = 4 * FLIT_W;

    tx_state_t          state, state_nxt;
    logic [BUF_W-1:0]   buf_q, buf_nxt;
    logic               type_q, type_nxt;
    logic [1:0]         body_left, body_left_nxt;
    logic [15:0]        cnt_q, cnt_nxt;
    logic               sel_en;
    logic [BUF_W-1:0]   buf_shifted;

    assign sel_en      = type_q ? en_local_rep_in : en_local_req_in;
    assign buf_shifted = {buf_q[BUF_W-FLIT_W-1:0], {FLIT_W{1'b0}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            buf_q     <= '0;
            type_q    <= 1'b0;
            body_left <= 2'd0;
            cnt_q     <= MSG_CNT_INIT;
        end else begin
            state     <= state_nxt;
            buf_q     <= buf_nxt;
            type_q    <= type_nxt;
            body_left <= body_left_nxt;
            cnt_q     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        buf_nxt       = buf_q;
        type_nxt      = type_q;
        body_left_nxt = body_left;
        cnt_nxt       = cnt_q;
        unique case (state)
            ST_IDLE: begin
                if (msg_valid) begin
                    buf_nxt       = msg_data;
                    type_nxt      = msg_type;
                    body_left_nxt = (msg_len == 2'd3) ? 2'd2 : msg_len;
                    state_nxt     = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (sel_en) begin
                    buf_nxt   = buf_shifted;
                    state_nxt = (body_left != 2'd0) ? ST_BODY : ST_TAIL;
                end
            end
            ST_BODY: begin
                if (sel_en) begin
                    buf_nxt       = buf_shifted;
                    body_left_nxt = body_left - 2'd1;
                    state_nxt     = (body_left == 2'd1) ? ST_TAIL : ST_BODY;
                end
            end
            ST_TAIL: begin
                if (sel_en) begin
                    cnt_nxt   = cnt_q + 16'd1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode state and buffer registers only; enables never reach them.
    always_comb begin
        ctrl_out      = CTRL_NONE;
        dest_fifo_out = DF_NONE;
        flit_out      = '0;
        unique case (state)
            ST_HEAD: ctrl_out = CTRL_HEAD;
            ST_BODY: ctrl_out = CTRL_BODY;
            ST_TAIL: ctrl_out = CTRL_TAIL;
            default: ctrl_out = CTRL_NONE;
        endcase
        if (state != ST_IDLE) begin
            flit_out      = buf_q[BUF_W-1 -: FLIT_W];
            dest_fifo_out = type_q ? DF_REP : DF_REQ;
        end
    end

    assign msg_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign msg_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ring_ni_tx.sv
// ============================================================================
// Module  : tb_ring_ni_tx
// Brief   : Directed self-checking bench for ring_ni_tx.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ring_ni_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst2 = 1'b0;
    logic        msg_valid = 1'b0;
    logic [63:0] msg_data = '0;
    logic [1:0]  msg_len = '0;
    logic        msg_type = 1'b0;
    logic        en_req = 1'b0;
    logic        en_rep = 1'b0;

    logic        msg_ready, busy;
    logic [15:0] flit_out, msg_cnt;
    logic [1:0]  ctrl_out, dest_fifo_out;

    logic        msg_ready2, busy2;
    logic [15:0] flit_out2, msg_cnt2;
    logic [1:0]  ctrl_out2, dest_fifo_out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ring_ni_tx dut (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_data(msg_data), .msg_len(msg_len), .msg_type(msg_type),
        .en_local_req_in(en_req), .en_local_rep_in(en_rep),
        .flit_out(flit_out), .ctrl_out(ctrl_out), .dest_fifo_out(dest_fifo_out),
        .busy(busy), .msg_cnt(msg_cnt)
    );

    // Second instance starts its counter one message short of wrapping.
    ring_ni_tx #(.MSG_CNT_INIT(16'hFFFF)) dut_wrap (
        .clk(clk), .rst(rst2), .msg_valid(msg_valid), .msg_ready(msg_ready2),
        .msg_data(msg_data), .msg_len(msg_len), .msg_type(msg_type),
        .en_local_req_in(en_req), .en_local_rep_in(en_rep),
        .flit_out(flit_out2), .ctrl_out(ctrl_out2), .dest_fifo_out(dest_fifo_out2),
        .busy(busy2), .msg_cnt(msg_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_flit(input string tag, input logic [15:0] f,
                               input logic [1:0] c, input logic [1:0] d);
        check({tag, "_flit"}, flit_out, f);
        check({tag, "_ctrl"}, ctrl_out, c);
        check({tag, "_dest"}, dest_fifo_out, d);
    endtask

    task automatic offer(input logic [63:0] d, input logic [1:0] l, input logic t);
        msg_valid = 1'b1;
        msg_data  = d;
        msg_len   = l;
        msg_type  = t;
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        check("rst_ctrl", ctrl_out, 2'b00);
        check("rst_flit", flit_out, 16'h0);
        check("rst_dest", dest_fifo_out, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt", msg_cnt, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ready", msg_ready, 1'b1);

        // Request message, no stall
        en_req = 1'b1;
        en_rep = 1'b0;
        offer(64'h1111_2222_3333_4444, 2'd2, 1'b0);
        tick();
        msg_valid = 1'b0;
        expect_flit("req_h", 16'h1111, 2'b01, 2'b01);
        check("req_busy", busy, 1'b1);
        check("req_ready", msg_ready, 1'b0);
        tick(); expect_flit("req_b0", 16'h2222, 2'b10, 2'b01);
        tick(); expect_flit("req_b1", 16'h3333, 2'b10, 2'b01);
        tick(); expect_flit("req_t", 16'h4444, 2'b11, 2'b01);
        check("req_cnt_pre", msg_cnt, 16'd0);
        tick();
        check("req_idle_ctrl", ctrl_out, 2'b00);
        check("req_cnt", msg_cnt, 16'd1);
        check("req_idle_ready", msg_ready, 1'b1);

        // Reply message with stall; request enable is high but must be ignored
        en_rep = 1'b0;
        en_req = 1'b1;
        offer(64'hAAAA_BBBB_CCCC_DDDD, 2'd0, 1'b1);
        tick();
        msg_valid = 1'b0;
        expect_flit("rep_h", 16'hAAAA, 2'b01, 2'b10);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_flit("rep_stall", 16'hAAAA, 2'b01, 2'b10);
        end
        en_rep = 1'b1;
        tick(); expect_flit("rep_t", 16'hBBBB, 2'b11, 2'b10);
        tick();
        check("rep_idle", ctrl_out, 2'b00);
        check("rep_cnt", msg_cnt, 16'd2);

        // Clamp (len 3 -> 2 bodies) and back-to-back
        en_rep = 1'b0;
        offer(64'h0123_4567_89AB_CDEF, 2'd3, 1'b0);
        tick();
        offer(64'hFEDC_BA98_7654_3210, 2'd1, 1'b0);
        expect_flit("clp_h", 16'h0123, 2'b01, 2'b01);
        tick(); expect_flit("clp_b0", 16'h4567, 2'b10, 2'b01);
        tick(); expect_flit("clp_b1", 16'h89AB, 2'b10, 2'b01);
        tick(); expect_flit("clp_t", 16'hCDEF, 2'b11, 2'b01);
        tick();
        check("b2b_gap", ctrl_out, 2'b00);
        check("b2b_gap_ready", msg_ready, 1'b1);
        tick();
        msg_valid = 1'b0;
        expect_flit("b2b_h", 16'hFEDC, 2'b01, 2'b01);
        tick(); expect_flit("b2b_b", 16'hBA98, 2'b10, 2'b01);
        tick(); expect_flit("b2b_t", 16'h7654, 2'b11, 2'b01);
        tick();
        check("b2b_cnt", msg_cnt, 16'd4);

        // Reset mid-body
        offer(64'h5555_6666_7777_8888, 2'd2, 1'b0);
        tick();
        msg_valid = 1'b0;
        tick();
        check("mid_in_body", ctrl_out, 2'b10);
        #2;
        rst = 1'b0;
        #1;
        check("mid_ctrl", ctrl_out, 2'b00);
        check("mid_busy", busy, 1'b0);
        check("mid_cnt", msg_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // Counter wrap on the preloaded instance
        rst2 = 1'b1;
        tick();
        check("wrap_pre", msg_cnt2, 16'hFFFF);
        offer(64'h9999_AAAA_0000_0000, 2'd0, 1'b0);
        tick();
        msg_valid = 1'b0;
        check("wrap_h", ctrl_out2, 2'b01);
        tick();
        check("wrap_t", flit_out2, 16'hAAAA);
        tick();
        check("wrap_cnt", msg_cnt2, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
